// File: rtl/grey_decode.sv
// grey_decode
// Sequential decoder for a NDIG-digit decimal counter whose digits are stored
// in a 5-bit single-step code. A start strobe snapshots all digits. Then one
// digit is converted per clock, most significant first, into a binary value
// and, optionally, a packed-BCD copy. Any digit code outside the legal set is
// flagged.
//
// Configuration macro: GREY_DEC_BCD_EN
//   defined   -> BCD register built, o_bcd carries the packed BCD result
//   undefined -> no BCD storage, o_bcd tied to 0
//
// Ports:
//   i_clk      in   1        clock, rising edge
//   i_rst_n    in   1        synchronous active-low reset
//   i_start    in   1        conversion request (accepted only when idle)
//   i_digits   in   5*NDIG   coded digits, ones at [4:0]
//   o_busy     out  1        conversion in progress
//   o_done     out  1        one-cycle pulse, results valid from this cycle on
//   o_value    out  OUT_W    binary result
//   o_bcd      out  4*NDIG   packed BCD result, ones at [3:0]
//   o_err      out  1        last conversion saw an illegal digit code
//   o_err_pos  out  4        index of the most significant illegal digit, else 0
module grey_decode #(
  parameter int NDIG  = 9,
  parameter int OUT_W = 30
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [5*NDIG-1:0] i_digits,
  output logic              o_busy,
  output logic              o_done,
  output logic [OUT_W-1:0]  o_value,
  output logic [4*NDIG-1:0] o_bcd,
  output logic              o_err,
  output logic [3:0]        o_err_pos
);

  localparam logic [3:0] LAST_IDX = 4'(NDIG - 1);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t state, state_nxt;

  logic [5*NDIG-1:0] snap;
  logic [OUT_W-1:0]  acc;
  logic [OUT_W-1:0]  acc_next;
  logic              err_acc;
  logic [3:0]        pos_acc;
  logic [3:0]        idx;
  logic [4:0]        cur_code;
  logic [3:0]        cur_dig;
  logic              cur_ok;
  logic              accept;
  logic              last_step;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples its inputs from before the edge, independent of order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start)     state_nxt = S_CONV;
      S_CONV:  if (idx == 4'd0) state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  assign o_busy    = (state == S_CONV);
  assign accept    = (state == S_IDLE) && i_start;
  assign last_step = (state == S_CONV) && (idx == 4'd0);

  // ---------------------------------------------------------------------------
  // Digit select and decode
  // ---------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case/loop so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cur_code = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (idx == 4'(k)) cur_code = snap[5*k +: 5];
    end
  end

  always_comb begin
    cur_dig = 4'd0;
    cur_ok  = 1'b1;
    case (cur_code)
      5'b00000: cur_dig = 4'd0;
      5'b00001: cur_dig = 4'd1;
      5'b00011: cur_dig = 4'd2;
      5'b00010: cur_dig = 4'd3;
      5'b00110: cur_dig = 4'd4;
      5'b00100: cur_dig = 4'd5;
      5'b01100: cur_dig = 4'd6;
      5'b01000: cur_dig = 4'd7;
      5'b11000: cur_dig = 4'd8;
      5'b10000: cur_dig = 4'd9;
      default:  cur_ok  = 1'b0;   // illegal code contributes 0
    endcase
  end

  // acc*10 built from two shifts; the result truncates to OUT_W.
  assign acc_next = (acc << 3) + (acc << 1) + {{(OUT_W-4){1'b0}}, cur_dig};

  // ---------------------------------------------------------------------------
  // Working registers
  // ---------------------------------------------------------------------------
  // NOTE: the snapshot and working registers are not reset; they are fully
  // reloaded on every accepted start and never reach an output before then.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      snap    <= i_digits;
      acc     <= '0;
      err_acc <= 1'b0;
      pos_acc <= 4'd0;
      idx     <= LAST_IDX;
    end else if (state == S_CONV) begin
      acc <= acc_next;
      // MSB-first walk: the first illegal digit met is the most significant.
      if (!cur_ok && !err_acc) begin
        err_acc <= 1'b1;
        pos_acc <= idx;
      end
      idx <= idx - 4'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Result registers: change only on the completing step
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_done    <= 1'b0;
      o_value   <= '0;
      o_err     <= 1'b0;
      o_err_pos <= 4'd0;
    end else begin
      o_done <= last_step;
      if (last_step) begin
        o_value   <= acc_next;
        o_err     <= err_acc | ~cur_ok;
        // idx is 0 on the last step, so a digit first failing here reports 0.
        o_err_pos <= err_acc ? pos_acc : 4'd0;
      end
    end
  end

`ifdef GREY_DEC_BCD_EN
  logic [4*NDIG-1:0] bcd_acc;

  always_ff @(posedge i_clk) begin
    if (accept) begin
      bcd_acc <= '0;
    end else if (state == S_CONV) begin
      for (int k = 0; k < NDIG; k++) begin
        if (idx == 4'(k)) bcd_acc[4*k +: 4] <= cur_dig;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_bcd <= '0;
    end else if (last_step) begin
      // Ones nibble is being decoded this very cycle; splice it in directly.
      o_bcd <= {bcd_acc[4*NDIG-1:4], cur_dig};
    end
  end
`else
  assign o_bcd = '0;
`endif

endmodule

// File: doc/grey_decode.md
# grey_decode

Sequential decoder for the 9-digit counter that stores each decimal digit in the team's 5-bit single-step code. On a start strobe it snapshots all digits, then converts one digit per clock, most significant first, into a 30-bit binary value and an optional packed-BCD copy. It sits between the counter and any consumer that needs plain arithmetic values, such as a serial readout, a comparator or a host register. It also flags any digit code outside the legal set.

## Interface
- NDIG, 9, number of digits; digit k occupies i_digits[5k+4:5k], with k=0 as ones.
- OUT_W, 30, width of o_value; must hold 10^NDIG-1.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset; synchronous to i_clk, active-low.
- i_start  in  1  conversion request, sampled each rising edge.
- i_digits  in  5*NDIG  coded digits, ones at [4:0].
- o_busy  out  1  conversion in progress.
- o_done  out  1  one-cycle pulse; results valid from this cycle on.
- o_value  out  OUT_W  binary result.
- o_bcd  out  4*NDIG  packed BCD, ones at [3:0].
- o_err  out  1  at least one illegal digit code in the last conversion.
- o_err_pos  out  4  index k of the most significant illegal digit; 0 if none.

## Operation
- Digit code map:
  - 0=00000, 1=00001, 2=00011, 3=00010, 4=00110
  - 5=00100, 6=01100, 7=01000, 8=11000, 9=10000
  - Every other code is illegal: it decodes as 0 and sets the error.
- State machine IDLE -> CONV -> IDLE:
  - IDLE: when i_start=1, capture i_digits into a snapshot register, clear the accumulator and error, set idx=NDIG-1, and go to CONV.
  - CONV: on each edge, acc <= acc*10 + dec(digit[idx]).
    - Implement *10 as (acc<<3)+(acc<<1), truncated to OUT_W.
    - Write BCD nibble idx.
    - On the first illegal digit seen, set the error flag and latch idx into the position.
    - idx decrements each edge.
  - When the idx=0 step completes, move the accumulator, BCD and error into the outputs, pulse o_done, and return to IDLE.
- Output registers change only on the o_done update. They hold their values between conversions.
- Illegal digits add 0 to the accumulator. The remaining digits still convert normally.
- i_digits is sampled only at start, so changes during CONV are ignored.

## Timing
- Start accepted at edge E0. o_busy is high from E0+1 through the cycle ending at edge E0+NDIG.
- o_done is high for exactly one cycle after edge E0+NDIG. Latency is NDIG cycles (9 by default).
- o_busy and o_done are never high together. During the o_done cycle the block is in IDLE.
- i_start during CONV is ignored and is not queued.
- i_start during the o_done cycle is accepted, giving back-to-back conversions at one result per NDIG+1 cycles.
- Reset (i_rst_n=0 at an edge):
  - state=IDLE; o_busy=0, o_done=0, o_value=0, o_bcd=0, o_err=0, o_err_pos=0.
  - Reset during CONV aborts with no o_done, and outputs read 0 afterwards.
  - Reset has priority over i_start on the same edge.
- Wrap-around: 999,999,999 (0x3B9AC9FF) fits in 30 bits, so no overflow occurs at defaults.

## Configuration
- GREY_DEC_BCD_EN defined: the BCD register is built and o_bcd carries the packed BCD result.
- GREY_DEC_BCD_EN undefined: the BCD register is removed and o_bcd is tied to 0. o_value, o_err and timing are unchanged.

## Test plan
- Reset, then code all digits as 0 and pulse start: o_done appears exactly 9 cycles after the start edge, with o_value=0, o_err=0 and o_busy high for 9 cycles.
- Digits 123456789 (hunM=00001 ... ones=10000): o_value=0x075BCD15 and o_bcd=0x123456789; with the macro undefined, o_bcd=0.
- All digits 9 (10000): o_value=0x3B9AC9FF and o_err=0.
- tens=11111, hund=01110, all other digits 0 apart from ones=5 (00100): o_value=5, o_err=1, o_err_pos=2.
- Pulse start again during CONV and change i_digits during CONV: exactly one o_done, and the result matches the digits sampled at the start edge.
- Drop i_rst_n at cycle 4 of a conversion: no o_done and all outputs read 0. Then start on the o_done cycle of a following conversion and check that two consecutive o_done pulses are 10 cycles apart.
